// File: rtl/mul_operand_feeder.sv
// Fetches IEEE-754 operand words from the host FIFO, pairs them A,B and presents them to the multiplier.
// Define MUL_FEEDER_SQUARE_EN to feed each FIFO word to both operands (x*x) instead.
`timescale 1ns/1ps
module mul_operand_feeder #(
  parameter int VEC_LEN = 128,
  parameter int CNT_W   = 8
) (
  input  logic             bus_clk,
  input  logic             reset,
  input  logic             fifo_rd_empty,
  output logic             fifo_rd_en,
  input  logic [31:0]      fifo_rd_data,
  output logic             s_axis_a_tvalid,
  input  logic             s_axis_a_tready,
  output logic [31:0]      s_axis_a_tdata,
  output logic             s_axis_b_tvalid,
  input  logic             s_axis_b_tready,
  output logic [31:0]      s_axis_b_tdata,
  output logic             op_last,
  output logic [CNT_W-1:0] pair_idx,
  output logic             vec_done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  typedef enum logic [2:0] {
    FETCH_A,
    WAIT_A,
    FETCH_B,
    WAIT_B,
    PRESENT
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             a_ok;
  logic             b_ok;
  logic             pair_done;
  logic             at_last;
  logic [CNT_W-1:0] next_idx;

  always_comb begin
    next_state = state;
    fifo_rd_en = ((state == FETCH_A) || (state == FETCH_B)) && !fifo_rd_empty && !reset;
    // A channel that already handshook counts as done while the other one waits.
    a_ok       = !s_axis_a_tvalid || s_axis_a_tready;
    b_ok       = !s_axis_b_tvalid || s_axis_b_tready;
    pair_done  = (state == PRESENT) && a_ok && b_ok;
    at_last    = (pair_idx == LAST_IDX);
    next_idx   = at_last ? '0 : pair_idx + CNT_W'(1);
    case (state)
      FETCH_A: if (fifo_rd_en) next_state = WAIT_A;
`ifdef MUL_FEEDER_SQUARE_EN
      WAIT_A:  next_state = PRESENT;
`else
      WAIT_A:  next_state = FETCH_B;
`endif
      FETCH_B: if (fifo_rd_en) next_state = WAIT_B;
      WAIT_B:  next_state = PRESENT;
      PRESENT: if (pair_done) next_state = FETCH_A;
      default: next_state = FETCH_A;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (reset) begin
      state           <= FETCH_A;
      s_axis_a_tvalid <= 1'b0;
      s_axis_b_tvalid <= 1'b0;
      s_axis_a_tdata  <= '0;
      s_axis_b_tdata  <= '0;
      op_last         <= 1'b0;
      pair_idx        <= '0;
      vec_done        <= 1'b0;
    end else begin
      state    <= next_state;
      vec_done <= pair_done && at_last;
      // Standard FIFO: the word strobed in FETCH_x is on fifo_rd_data during WAIT_x.
      if (state == WAIT_A) begin
        s_axis_a_tdata <= fifo_rd_data;
`ifdef MUL_FEEDER_SQUARE_EN
        s_axis_b_tdata  <= fifo_rd_data;
        s_axis_a_tvalid <= 1'b1;
        s_axis_b_tvalid <= 1'b1;
`endif
      end
      if (state == WAIT_B) begin
        s_axis_b_tdata  <= fifo_rd_data;
        s_axis_a_tvalid <= 1'b1;
        s_axis_b_tvalid <= 1'b1;
      end
      if (s_axis_a_tvalid && s_axis_a_tready) s_axis_a_tvalid <= 1'b0;
      if (s_axis_b_tvalid && s_axis_b_tready) s_axis_b_tvalid <= 1'b0;
      if (pair_done) begin
        pair_idx <= next_idx;
        op_last  <= (next_idx == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Randomized self-checking bench for mul_operand_feeder; expected pairs come from the word order pushed into a FIFO model.
`timescale 1ns/1ps
module tb_mul_operand_feeder;

  localparam int VL = 4;
  localparam int CW = 8;
`ifdef MUL_FEEDER_SQUARE_EN
  localparam int WPP = 1;
`else
  localparam int WPP = 2;
`endif

  logic          bus_clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_rd_empty;
  logic          fifo_rd_en;
  logic [31:0]   fifo_rd_data = '0;
  logic          s_axis_a_tvalid, s_axis_b_tvalid;
  logic          a_ready = 1'b0, b_ready = 1'b0;
  logic [31:0]   s_axis_a_tdata, s_axis_b_tdata;
  logic          op_last, vec_done;
  logic [CW-1:0] pair_idx;
  logic          hold_empty = 1'b0;

  logic [31:0] fifo_mem [0:1023];
  int wr_ptr = 0, rd_ptr = 0;
  int checks = 0, failures = 0;
  int rd_cnt = 0, bad_rd = 0, vec_cnt = 0;
  logic rd_seen = 1'b0;
  logic [31:0]   acc_a[$], acc_b[$];
  logic [CW-1:0] acc_idx[$];
  logic          acc_last[$];

  assign fifo_rd_empty = hold_empty || (wr_ptr == rd_ptr);

  always #5 bus_clk = ~bus_clk;

  mul_operand_feeder #(.VEC_LEN(VL), .CNT_W(CW)) dut (
    .bus_clk(bus_clk), .reset(reset),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .s_axis_a_tvalid(s_axis_a_tvalid), .s_axis_a_tready(a_ready), .s_axis_a_tdata(s_axis_a_tdata),
    .s_axis_b_tvalid(s_axis_b_tvalid), .s_axis_b_tready(b_ready), .s_axis_b_tdata(s_axis_b_tdata),
    .op_last(op_last), .pair_idx(pair_idx), .vec_done(vec_done)
  );

  // FIFO model: strobe sampled at the edge, word presented for the following cycle.
  always @(posedge bus_clk) begin
    rd_seen <= fifo_rd_en;
    if (fifo_rd_en && (fifo_rd_empty || s_axis_a_tvalid || s_axis_b_tvalid)) bad_rd = bad_rd + 1;
  end

  always @(negedge bus_clk) begin
    if (rd_seen) begin
      fifo_rd_data = fifo_mem[rd_ptr % 1024];
      rd_ptr = rd_ptr + 1;
      rd_cnt = rd_cnt + 1;
    end
    if (!reset) begin
      if (s_axis_a_tvalid && a_ready) begin
        acc_a.push_back(s_axis_a_tdata);
        acc_idx.push_back(pair_idx);
        acc_last.push_back(op_last);
      end
      if (s_axis_b_tvalid && b_ready) acc_b.push_back(s_axis_b_tdata);
      if (vec_done) vec_cnt = vec_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge bus_clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] v);
    fifo_mem[wr_ptr % 1024] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic clear_mon();
    acc_a.delete(); acc_b.delete(); acc_idx.delete(); acc_last.delete();
    vec_cnt = 0;
    rd_cnt  = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; a_ready = 1'b0; b_ready = 1'b0; hold_empty = 1'b0;
    tick(2);
    rd_ptr = wr_ptr;
    clear_mon();
    reset = 1'b0;
  endtask

  task automatic wait_pairs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (acc_a.size() >= n && acc_b.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    push(32'h1234_5678);
    tick(2);
    checks++;
    if ({fifo_rd_en, s_axis_a_tvalid, s_axis_b_tvalid, op_last, vec_done} !== 5'b0) begin
      failures++;
      $display("FAIL rst_ctrl got=%b exp=00000", {fifo_rd_en, s_axis_a_tvalid, s_axis_b_tvalid, op_last, vec_done});
    end
    checks++;
    if ({s_axis_a_tdata, s_axis_b_tdata} !== 64'h0) begin
      failures++;
      $display("FAIL rst_data got=%h/%h exp=0", s_axis_a_tdata, s_axis_b_tdata);
    end
    checks++;
    if (pair_idx !== '0) begin
      failures++;
      $display("FAIL rst_idx got=%0d exp=0", pair_idx);
    end
    rd_ptr = wr_ptr;
  endtask

  task automatic test_first_pair();
    int lat;
    reset = 1'b1;
    tick(1);
    rd_ptr = wr_ptr;
    clear_mon();
    a_ready = 1'b1; b_ready = 1'b1;
    push(32'h3F99_999A);
    push(32'h3F99_999A);
    reset = 1'b0;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL first_strobe got=%b exp=1", fifo_rd_en);
    end
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      tick(1);
      if (lat < 0 && s_axis_a_tvalid === 1'b1 && s_axis_b_tvalid === 1'b1) lat = c;
    end
    checks++;
    if (lat != 2 * WPP) begin
      failures++;
      $display("FAIL first_latency got=%0d exp=%0d", lat, 2 * WPP);
    end
    tick(6);
    checks++;
    if (rd_cnt != 2) begin
      failures++;
      $display("FAIL first_strobes got=%0d exp=2", rd_cnt);
    end
    checks++;
    if (acc_a.size() != 2 / WPP || acc_b.size() != 2 / WPP) begin
      failures++;
      $display("FAIL first_count got=%0d/%0d exp=%0d", acc_a.size(), acc_b.size(), 2 / WPP);
    end else begin
      checks++;
      if (acc_a[0] !== 32'h3F99_999A || acc_b[0] !== 32'h3F99_999A || acc_idx[0] !== '0 || acc_last[0] !== 1'b0) begin
        failures++;
        $display("FAIL first_pair got=%h,%h idx=%0d last=%b exp=3f99999a,3f99999a idx=0 last=0",
                 acc_a[0], acc_b[0], acc_idx[0], acc_last[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[$];
    logic [31:0] bcap;
    bit ok;
    do_reset();
    for (int i = 0; i < 2 * WPP; i++) begin
      w.push_back($urandom);
      push(w[i]);
    end
    a_ready = 1'b1; b_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick(1);
      if (s_axis_a_tvalid === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_valid got=timeout exp=tvalid within 20 cycles");
    end
    bcap = s_axis_b_tdata;
    for (int c = 0; c < 7; c++) begin
      tick(1);
      checks++;
      if ({s_axis_a_tvalid, s_axis_b_tvalid, fifo_rd_en} !== 3'b010) begin
        failures++;
        $display("FAIL bp_ctrl cycle=%0d got={avld,bvld,rd}=%b exp=010", c, {s_axis_a_tvalid, s_axis_b_tvalid, fifo_rd_en});
      end
      checks++;
      if (s_axis_b_tdata !== bcap) begin
        failures++;
        $display("FAIL bp_bdata cycle=%0d got=%h exp=%h", c, s_axis_b_tdata, bcap);
      end
    end
    checks++;
    if (acc_a.size() != 1 || acc_b.size() != 0 || rd_cnt != WPP) begin
      failures++;
      $display("FAIL bp_hold got=a%0d b%0d rd%0d exp=a1 b0 rd%0d", acc_a.size(), acc_b.size(), rd_cnt, WPP);
    end
    b_ready = 1'b1;
    wait_pairs(2, 40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_resume got=%0d pairs exp=2", acc_b.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (acc_a[k] !== w[k * WPP] || acc_b[k] !== w[k * WPP + WPP - 1] || acc_idx[k] !== CW'(k)) begin
          failures++;
          $display("FAIL bp_pair%0d got=%h,%h idx=%0d exp=%h,%h idx=%0d", k, acc_a[k], acc_b[k], acc_idx[k],
                   w[k * WPP], w[k * WPP + WPP - 1], k);
        end
      end
    end
  endtask

  task automatic test_vector_last();
    bit ok;
    int np;
    do_reset();
    a_ready = 1'b1; b_ready = 1'b1;
    np = VL + 1;
    for (int i = 0; i < WPP * np; i++) push(32'(i + 1));
    wait_pairs(np, 200, ok);
    tick(3);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL vec_count got=%0d pairs exp=%0d", acc_b.size(), np);
    end else begin
      for (int k = 0; k < np; k++) begin
        checks++;
        if (acc_a[k] !== 32'(k * WPP + 1) || acc_b[k] !== 32'(k * WPP + WPP) ||
            acc_idx[k] !== CW'(k % VL) || acc_last[k] !== ((k % VL) == VL - 1)) begin
          failures++;
          $display("FAIL vec_pair%0d got=%0d,%0d idx=%0d last=%b exp=%0d,%0d idx=%0d last=%b", k,
                   acc_a[k], acc_b[k], acc_idx[k], acc_last[k], k * WPP + 1, k * WPP + WPP, k % VL,
                   (k % VL) == VL - 1);
        end
      end
    end
    checks++;
    if (vec_cnt != 1) begin
      failures++;
      $display("FAIL vec_done_pulses got=%0d exp=1", vec_cnt);
    end
  endtask

  task automatic test_empty_gap();
    logic [31:0] w[$];
    bit ok;
    do_reset();
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 2 * WPP; i++) w.push_back($urandom);
    for (int i = 0; i < 2 * WPP - 1; i++) push(w[i]);
    wait_pairs(1, 40, ok);
    tick(3);
    for (int c = 0; c < 10; c++) begin
      tick(1);
      checks++;
      if ({fifo_rd_en, s_axis_a_tvalid, s_axis_b_tvalid} !== 3'b000) begin
        failures++;
        $display("FAIL gap_stall cycle=%0d got={rd,avld,bvld}=%b exp=000", c, {fifo_rd_en, s_axis_a_tvalid, s_axis_b_tvalid});
      end
    end
    push(w[2 * WPP - 1]);
    wait_pairs(2, 40, ok);
    checks++;
    if (!ok || acc_a.size() != 2) begin
      failures++;
      $display("FAIL gap_count got=%0d pairs exp=2", acc_a.size());
    end else begin
      checks++;
      if (acc_a[1] !== w[WPP] || acc_b[1] !== w[2 * WPP - 1] || acc_idx[1] !== CW'(1)) begin
        failures++;
        $display("FAIL gap_pair got=%h,%h idx=%0d exp=%h,%h idx=1", acc_a[1], acc_b[1], acc_idx[1], w[WPP], w[2 * WPP - 1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w[$];
    bit ok;
    do_reset();
    for (int i = 0; i < 2 * WPP; i++) begin
      w.push_back($urandom);
      push(w[i]);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick(1);
      if (s_axis_a_tvalid === 1'b1 && s_axis_b_tvalid === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_present got=timeout exp=both tvalid");
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if ({fifo_rd_en, s_axis_a_tvalid, s_axis_b_tvalid, op_last, vec_done} !== 5'b0 ||
        {s_axis_a_tdata, s_axis_b_tdata} !== 64'h0 || pair_idx !== '0) begin
      failures++;
      $display("FAIL mid_reset got=ctrl%b a=%h b=%h idx=%0d exp=all zero",
               {fifo_rd_en, s_axis_a_tvalid, s_axis_b_tvalid, op_last, vec_done}, s_axis_a_tdata, s_axis_b_tdata, pair_idx);
    end
    clear_mon();
    reset = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1;
    wait_pairs(1, 40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_resume got=%0d pairs exp=1", acc_b.size());
    end else begin
      checks++;
      if (acc_a[0] !== w[WPP] || acc_b[0] !== w[2 * WPP - 1] || acc_idx[0] !== '0) begin
        failures++;
        $display("FAIL mid_pair got=%h,%h idx=%0d exp=%h,%h idx=0", acc_a[0], acc_b[0], acc_idx[0], w[WPP], w[2 * WPP - 1]);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [31:0] w[$];
    int n, np, perr;
    do_reset();
    np = VL * 3;
    n  = WPP * np;
    for (int i = 0; i < n; i++) begin
      w.push_back($urandom);
      push(w[i]);
    end
    for (int c = 0; c < 3000; c++) begin
      if (acc_a.size() >= np && acc_b.size() >= np) break;
      a_ready    = 1'($urandom_range(0, 1));
      b_ready    = 1'($urandom_range(0, 1));
      hold_empty = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    a_ready = 1'b1; b_ready = 1'b1; hold_empty = 1'b0;
    tick(3);
    checks++;
    if (acc_a.size() != np || acc_b.size() != np) begin
      failures++;
      $display("FAIL rnd_count got=%0d/%0d exp=%0d", acc_a.size(), acc_b.size(), np);
    end else begin
      perr = 0;
      for (int k = 0; k < np; k++) begin
        checks++;
        if (acc_a[k] !== w[k * WPP] || acc_b[k] !== w[k * WPP + WPP - 1] ||
            acc_idx[k] !== CW'(k % VL) || acc_last[k] !== ((k % VL) == VL - 1)) begin
          failures++;
          perr++;
          if (perr <= 4)
            $display("FAIL rnd_pair%0d got=%h,%h idx=%0d last=%b exp=%h,%h idx=%0d last=%b", k, acc_a[k], acc_b[k],
                     acc_idx[k], acc_last[k], w[k * WPP], w[k * WPP + WPP - 1], k % VL, (k % VL) == VL - 1);
        end
      end
    end
    checks++;
    if (vec_cnt != 3) begin
      failures++;
      $display("FAIL rnd_vec_done got=%0d exp=3", vec_cnt);
    end
    checks++;
    if (rd_cnt != n) begin
      failures++;
      $display("FAIL rnd_strobes got=%0d exp=%0d", rd_cnt, n);
    end
    checks++;
    if (bad_rd != 0) begin
      failures++;
      $display("FAIL illegal_reads got=%0d exp=0", bad_rd);
    end
  endtask

  initial begin
    test_reset();
    test_first_pair();
    test_backpressure();
    test_vector_last();
    test_empty_gap();
    test_reset_mid();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
